dmem_arbiter: RTL and testbench

- Two-master arbiter in front of the shared data-memory/IO slave (word-addressed DRAM plus the addr[7] IO window).
- Master 0 is the CPU MEM stage; master 1 is a secondary requester (DMA / debug loader).
- Registers the winning request, drives one slave access, returns read data with a single-cycle ack, and rotates priority.
- Rejects misaligned accesses without touching the slave.

---
 rtl/dmem_arbiter.sv | 150 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the shared data-memory/IO slave: registers the winning
// request, performs one slave access, and returns a single-cycle ack.
module dmem_arbiter #(
    parameter bit          FIXED_PRIO = 1'b0,
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32
) (
    input  logic          clock,
    input  logic          reset,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_ack,
    output logic          m0_err,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_ack,
    output logic          m1_err,
    output logic [DW-1:0] m1_rdata,

    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    output logic          s_we,
    input  logic [DW-1:0] s_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        ERRS
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          lat_we;
    logic          lat_win;
    logic          last_win;
    logic [DW-1:0] m0_rdata_q;
    logic [DW-1:0] m1_rdata_q;

    logic          win_nx;
    logic          grant;
    logic          ack;
    logic          rd_pass;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_we;

    // Winner selection: a lone requester wins; ties go to master 0 or alternate.
    always_comb begin
        win_nx = 1'b0;
        if (m0_req && m1_req) begin
            win_nx = FIXED_PRIO ? 1'b0 : ~last_win;
        end else if (m1_req) begin
            win_nx = 1'b1;
        end
        sel_addr  = win_nx ? m1_addr  : m0_addr;
        sel_wdata = win_nx ? m1_wdata : m0_wdata;
        sel_we    = win_nx ? m1_we    : m0_we;
    end

    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        ack      = 1'b0;
        s_we     = 1'b0;
        m0_err   = 1'b0;
        m1_err   = 1'b0;
        case (state)
            IDLE: begin
                if ((m0_req || m1_req) && !reset) begin
                    grant    = 1'b1;
                    state_nx = (sel_addr[1:0] != 2'b00) ? ERRS : ACCESS;
                end
            end
            ACCESS: begin
                s_we     = lat_we;
                state_nx = RESP;
            end
            RESP: begin
                ack      = !reset;
                state_nx = IDLE;
            end
            ERRS: begin
                ack      = !reset;
                m0_err   = !reset && !lat_win;
                m1_err   = !reset && lat_win;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign m0_gnt  = grant && !win_nx;
    assign m1_gnt  = grant && win_nx;
    assign m0_ack  = ack && !lat_win;
    assign m1_ack  = ack && lat_win;
    assign s_addr  = lat_addr;
    assign s_wdata = lat_wdata;
    assign busy    = (state != IDLE);

    // Read data passes straight through during RESP so it is valid with ack,
    // and the captured copy holds it until the next read completes.
    assign rd_pass  = (state == RESP) && !lat_we && !reset;
    assign m0_rdata = (rd_pass && !lat_win) ? s_rdata : m0_rdata_q;
    assign m1_rdata = (rd_pass && lat_win)  ? s_rdata : m1_rdata_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_we     <= 1'b0;
            lat_win    <= 1'b0;
            last_win   <= 1'b1;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                lat_addr  <= sel_addr;
                lat_wdata <= sel_wdata;
                lat_we    <= sel_we;
                lat_win   <= win_nx;
                last_win  <= win_nx;
            end
            if (rd_pass) begin
                if (lat_win) begin
                    m1_rdata_q <= s_rdata;
                end else begin
                    m0_rdata_q <= s_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: round-robin and fixed-priority instances,
// with an ack scoreboard checking who completed, err and read data.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;

    logic        m0_gnt, m0_ack, m0_err, m1_gnt, m1_ack, m1_err, s_we, busy;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata, rd_a;
    logic        f_m0_gnt, f_m0_ack, f_m0_err, f_m1_gnt, f_m1_ack, f_m1_err, f_s_we, f_busy;
    logic [31:0] f_m0_rdata, f_m1_rdata, f_s_addr, f_s_wdata, rd_b;

    typedef struct {
        logic        who;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b1;
    logic [31:0] exp_rd0 = '0;
    logic [31:0] exp_rd1 = '0;

    always #5 clock = ~clock;

    dmem_arbiter #(.FIXED_PRIO(1'b0), .AW(32), .DW(32)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we), .s_rdata(rd_a), .busy(busy)
    );

    dmem_arbiter #(.FIXED_PRIO(1'b1), .AW(32), .DW(32)) dut_fp (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(f_m0_gnt), .m0_ack(f_m0_ack), .m0_err(f_m0_err), .m0_rdata(f_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(f_m1_gnt), .m1_ack(f_m1_ack), .m1_err(f_m1_err), .m1_rdata(f_m1_rdata),
        .s_addr(f_s_addr), .s_wdata(f_s_wdata), .s_we(f_s_we), .s_rdata(rd_b), .busy(f_busy)
    );

    function automatic logic [31:0] slave_fn(input logic [31:0] a);
        return 32'h1234_5678 ^ ((a - 32'd4) << 8);
    endfunction

    // Slave model: data for the address presented appears one cycle later.
    always @(posedge clock) begin
        rd_a <= slave_fn(s_addr);
        rd_b <= slave_fn(f_s_addr);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic who, input logic err, input logic [31:0] rdata);
        exp_t e;
        e.who = who;
        e.err = err;
        e.rdata = rdata;
        sb.push_back(e);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (mon_en && !reset && (m0_ack || m1_ack)) begin
            chk("sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_ack_who", {m1_ack, m0_ack}, e.who ? 2'b10 : 2'b01);
                chk("sb_err", e.who ? m1_err : m0_err, e.err);
                chk("sb_rdata", e.who ? m1_rdata : m0_rdata, e.rdata);
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_busy", busy, 1'b0);
        chk("rst_s_addr", s_addr, 32'h0);
        chk("rst_s_wdata", s_wdata, 32'h0);
        chk("rst_s_we", s_we, 1'b0);
        chk("rst_rdata", {m1_rdata, m0_rdata}, 64'h0);
        chk("rst_acks", {m0_ack, m1_ack, m0_gnt, m1_gnt}, 4'b0);
        reset = 1'b0;

        // Single read by m0
        @(negedge clock);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h04;
        #1 chk("rd_gnt", {m1_gnt, m0_gnt}, 2'b01);
        exp_rd0 = slave_fn(32'h04);
        push(1'b0, 1'b0, exp_rd0);
        @(negedge clock);
        chk("rd_s_addr", s_addr, 32'h04);
        chk("rd_s_we", s_we, 1'b0);
        chk("rd_busy", busy, 1'b1);
        @(negedge clock);
        chk("rd_ack", m0_ack, 1'b1);
        chk("rd_data_val", m0_rdata, 32'h1234_5678);
        m0_req = 1'b0;
        @(negedge clock);
        chk("rd_hold", m0_rdata, exp_rd0);
        chk("rd_idle", busy, 1'b0);

        // Single write by m1 into the IO window
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h80; m1_wdata = 32'hA5;
        #1 chk("wr_gnt", {m1_gnt, m0_gnt}, 2'b10);
        push(1'b1, 1'b0, exp_rd1);
        @(negedge clock);
        chk("wr_s_we", s_we, 1'b1);
        chk("wr_s_addr", s_addr, 32'h80);
        chk("wr_s_wdata", s_wdata, 32'hA5);
        @(negedge clock);
        chk("wr_s_we_off", s_we, 1'b0);
        chk("wr_ack", m1_ack, 1'b1);
        m1_req = 1'b0; m1_we = 1'b0;

        // Round-robin tie: m0, m1, m0, m1 with acks every third cycle
        @(negedge clock);
        m0_req = 1'b1; m0_addr = 32'h08;
        m1_req = 1'b1; m1_addr = 32'h0C;
        for (int t = 0; t < 4; t++) begin
            logic w;
            w = (t % 2) == 1;
            if (t > 0) @(negedge clock);
            #1 chk("rr_gnt", {m1_gnt, m0_gnt}, w ? 2'b10 : 2'b01);
            if (w) begin
                exp_rd1 = slave_fn(32'h0C);
                push(1'b1, 1'b0, exp_rd1);
            end else begin
                exp_rd0 = slave_fn(32'h08);
                push(1'b0, 1'b0, exp_rd0);
            end
            @(negedge clock);
            @(negedge clock);
            chk("rr_ack", w ? m1_ack : m0_ack, 1'b1);
        end
        m0_req = 1'b0; m1_req = 1'b0;

        // Misaligned m0 read, then a tie at N+2 that m1 must win
        @(negedge clock);
        m0_req = 1'b1; m0_addr = 32'h06;
        #1 chk("mis_gnt", {m1_gnt, m0_gnt}, 2'b01);
        push(1'b0, 1'b1, exp_rd0);
        @(negedge clock);
        chk("mis_ack_err", {m0_ack, m0_err}, 2'b11);
        chk("mis_s_we", s_we, 1'b0);
        m0_addr = 32'h10;
        m1_req = 1'b1; m1_addr = 32'h18;
        @(negedge clock);
        #1 chk("mis_next_gnt", {m1_gnt, m0_gnt}, 2'b10);
        exp_rd1 = slave_fn(32'h18);
        push(1'b1, 1'b0, exp_rd1);
        @(negedge clock);
        @(negedge clock);
        chk("mis_m1_ack", m1_ack, 1'b1);
        m1_req = 1'b0;
        @(negedge clock);
        #1 chk("mis_m0_gnt", {m1_gnt, m0_gnt}, 2'b01);
        exp_rd0 = slave_fn(32'h10);
        push(1'b0, 1'b0, exp_rd0);
        @(negedge clock);
        @(negedge clock);
        chk("mis_m0_ack", m0_ack, 1'b1);
        m0_req = 1'b0;

        // Reset during a write ACCESS drops the transaction
        @(negedge clock);
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'hDEAD_BEEF;
        #1 chk("rw_gnt", m0_gnt, 1'b1);
        @(negedge clock);
        chk("rw_s_we", s_we, 1'b1);
        chk("rw_s_wdata", s_wdata, 32'hDEAD_BEEF);
        reset = 1'b1;
        @(negedge clock);
        chk("rw_s_we_off", s_we, 1'b0);
        chk("rw_no_ack", {m0_ack, m1_ack, m0_gnt, m1_gnt, busy}, 5'b0);
        chk("rw_s_clr", {s_addr, s_wdata}, 64'h0);
        chk("rw_rd_clr", {m1_rdata, m0_rdata}, 64'h0);
        m0_req = 1'b0; m0_we = 1'b0;
        exp_rd0 = '0; exp_rd1 = '0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        m0_req = 1'b1; m0_addr = 32'h24;
        m1_req = 1'b1; m1_addr = 32'h28;
        #1 chk("rw_tie_gnt", {m1_gnt, m0_gnt}, 2'b01);
        exp_rd0 = slave_fn(32'h24);
        push(1'b0, 1'b0, exp_rd0);
        @(negedge clock);
        @(negedge clock);
        chk("rw_tie_ack", m0_ack, 1'b1);
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clock);
        chk("sb_drained", sb.size(), 0);

        // Fixed priority instance: m0 wins three ties, m1 only after m0 drops
        mon_en = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        m0_req = 1'b1; m0_addr = 32'h30;
        m1_req = 1'b1; m1_addr = 32'h34;
        for (int t = 0; t < 3; t++) begin
            if (t > 0) @(negedge clock);
            #1 chk("fp_gnt", {f_m1_gnt, f_m0_gnt}, 2'b01);
            @(negedge clock);
            @(negedge clock);
            chk("fp_ack", {f_m1_ack, f_m0_ack}, 2'b01);
            chk("fp_rdata", f_m0_rdata, slave_fn(32'h30));
            if (t == 2) m0_req = 1'b0;
        end
        @(negedge clock);
        #1 chk("fp_m1_gnt", {f_m1_gnt, f_m0_gnt}, 2'b10);
        @(negedge clock);
        @(negedge clock);
        chk("fp_m1_ack", {f_m1_ack, f_m1_err}, 2'b10);
        chk("fp_m1_rdata", f_m1_rdata, slave_fn(32'h34));
        m1_req = 1'b0;
        @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
